mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
//  MEM-stage memory access unit; consumes the request held by the EX/MEM latch and services it on the data bus.
//  Converts address, store data and access size into a word-aligned bus transaction with byte enables.
//  Waits for the responder ack and freezes the pipeline meanwhile; stall_o drives the latch EN low.
//  Aligns and sign/zero-extends load data before it goes to the MEM/WB latch.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max REQ cycles without bus_ack_i before abort; range 2..65535
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  mem_en_i       in   1   MEM-stage instruction accesses memory/MIO (MIO_MEM)
//  we_i           in   1   1 = store, 0 = load (WR_MEM)
//  addr_i         in   32  byte address (ALUO_MEM)
//  wdata_i        in   32  store data, LSB-justified (Datao_MEM)
//  ubhw_i         in   3   [2]=unsigned load; [1:0] 00=byte 01=half 10=word 11=word (u_b_h_w_MEM)
//  bus_req_o      out  1   transaction request, held until ack or timeout
//  bus_we_o       out  1   write strobe
//  bus_addr_o     out  32  {addr_i[31:2],2'b00}
//  bus_wdata_o    out  32  lane-replicated store data
//  bus_be_o       out  4   byte enables
//  bus_rdata_i    in   32  read data, valid with bus_ack_i
//  bus_ack_i      in   1   responder completion, single-cycle pulse
//  stall_o        out  1   freeze IF..MEM (EX/MEM EN = ~stall_o)
//  rdata_o        out  32  extended load data, held until next DONE
//  rdata_valid_o  out  1   1-cycle pulse in DONE for completed loads
//  bus_err_o      out  1   1-cycle pulse in DONE after timeout abort
//  misalign_o     out  1   1-cycle pulse on misaligned access (macro only; else 0)
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0, all outputs 0; asynchronous, also mid-transaction (req dropped).
//  States: IDLE -> REQ -> DONE -> IDLE.
//  IDLE: mem_en_i=1 -> latch bus_addr/we/wdata/be (and unsigned/size), go REQ; stall_o=mem_en_i (combinational).
//  REQ: bus_req_o=1, stall_o=1; bus_ack_i=1 -> capture extended load data into rdata_o, go DONE.
//       no ack: counter+1; counter=TIMEOUT_CYCLES-1 -> drop req, rdata_o=0, flag error, go DONE.
//  DONE: stall_o=0, bus_req_o=0; latch advances at end of cycle; mem_en_i ignored; go IDLE.
//  Latency: ack in first REQ cycle -> 3 cycles, stall_o high for 2 of them.
//  bus_ack_i outside REQ ignored; store in DONE: rdata_o unchanged, rdata_valid_o=0.
//  Byte enables: byte be=4'b0001<<addr[1:0]; half be=addr[1]?4'b1100:4'b0011; word/11 be=4'b1111.
//  Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  Load: byte lane addr[1:0]*8, half lane addr[1]*16; sign-extend if ubhw[2]=0, else zero-extend; word as-is.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus req;
//    IDLE -> DONE directly, misalign_o=1 in DONE, rdata_o=0, rdata_valid_o=0, stall_o high in IDLE cycle only.
//  Undefined: low address bits ignored beyond lane select (forced alignment); misalign_o tied 0.
// TESTING
//  Word load addr=0x100, ack after 2 cycles, rdata=0xDEADBEEF -> bus_be=1111, stall 3 cycles, rdata_o=0xDEADBEEF.
//  Signed byte load addr=0x103, rdata=0x80xxxxxx -> be=1000, rdata_o=0xFFFFFF80; unsigned -> 0x00000080.
//  Half store addr=0x102, wdata=0x1234ABCD -> bus_wdata=0xABCDABCD, be=1100, we=1, no rdata_valid.
//  No ack, TIMEOUT_CYCLES=4 -> req drops after 4 REQ cycles, bus_err_o pulse, rdata_o=0, stall released.
//  rst asserted in REQ -> bus_req_o and stall_o 0 same cycle; next mem_en_i starts clean IDLE->REQ.
//  MISALIGN_TRAP_EN: word load addr=0x101 -> no bus_req_o, misalign_o pulse; undefined: be=1111, addr 0x100.

Source files
------------

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access unit: builds aligned bus transactions, stalls until ack/timeout,
// and extends load data. Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ubhw_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        trap_s;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lane, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{lane, 3'b000} +: 8];
    h = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Misaligned-access detection; without the trap, low address bits only pick lanes.
`ifdef MISALIGN_TRAP_EN
  always_comb begin
    trap_s = 1'b0;
    case (ubhw_i[1:0])
      2'b00:   trap_s = 1'b0;
      2'b01:   trap_s = addr_i[0];
      default: trap_s = (addr_i[1:0] != 2'b00);
    endcase
  end
`else
  assign trap_s = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Stall: request phase of IDLE follows mem_en_i directly, REQ always holds the pipeline.
  always_comb begin
    stall_o = 1'b0;
    case (state_r)
      ST_IDLE: stall_o = mem_en_i;
      ST_REQ:  stall_o = 1'b1;
      ST_DONE: stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      uns_r         <= 1'b0;
      size_r        <= 2'b00;
      lane_r        <= 2'b00;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 32'd0;
      bus_wdata_o   <= 32'd0;
      bus_be_o      <= 4'd0;
      rdata_o       <= 32'd0;
      rdata_valid_o <= 1'b0;
      bus_err_o     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          rdata_valid_o <= 1'b0;
          bus_err_o     <= 1'b0;
          cnt_r         <= 16'd0;
`ifdef MISALIGN_TRAP_EN
          misalign_o    <= 1'b0;
`endif
          if (mem_en_i && trap_s) begin
            // Trapped access never reaches the bus; result slot is cleared.
            state_r <= ST_DONE;
            rdata_o <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b1;
`endif
          end else if (mem_en_i) begin
            state_r     <= ST_REQ;
            bus_req_o   <= 1'b1;
            bus_we_o    <= we_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= calc_wdata(ubhw_i[1:0], wdata_i);
            bus_be_o    <= calc_be(ubhw_i[1:0], addr_i[1:0]);
            uns_r       <= ubhw_i[2];
            size_r      <= ubhw_i[1:0];
            lane_r      <= addr_i[1:0];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_ack_i) begin
            state_r   <= ST_DONE;
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              rdata_o       <= extend_load(size_r, uns_r, lane_r, bus_rdata_i);
              rdata_valid_o <= 1'b1;
            end else begin
              rdata_valid_o <= 1'b0;
            end
          end else if (cnt_r == TMO_LAST) begin
            state_r   <= ST_DONE;
            bus_req_o <= 1'b0;
            rdata_o   <= 32'd0;
            bus_err_o <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          state_r       <= ST_IDLE;
          cnt_r         <= 16'd0;
          rdata_valid_o <= 1'b0;
          bus_err_o     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_o    <= 1'b0;
`endif
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed, table-driven bench for mem_stage_access (TIMEOUT_CYCLES=4) plus timeout,
// reset-in-REQ, stray-ack and misalignment sequences.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ubhw;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ubhw_i(ubhw), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_be_o(bus_be),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .stall_o(stall),
    .rdata_o(rdata), .rdata_valid_o(rdata_valid), .bus_err_o(bus_err),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ubhw;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] baddr;
    logic [31:0] exp_rdata;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at #1 after a rising edge; returns at #1 after the edge following DONE.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls;
    stalls = 0;
    mem_en = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; ubhw = v.ubhw;
    #1;
    if (stall) stalls++;
    @(posedge clk); #1;
    mem_en = 1'b0;
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, v.be});
    chk({tag, "_addr"}, bus_addr, v.baddr);
    chk({tag, "_wdata"}, bus_wdata, v.bwdata);
    chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, v.we});
    for (int d = 0; d < v.delay; d++) begin
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    if (stall) stalls++;
    bus_ack = 1'b1; bus_rdata = v.rdata;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h5A5A5A5A;
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, rdata_valid}, {31'd0, v.exp_valid});
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.delay + 2));
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, {31'd0, rdata_valid}, 32'd0);
  endtask

  initial begin
    int reqc;
    vec_t mv;
    vecs[0] = '{1'b0, 32'h00000100, 32'h0, 3'b010, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 32'h100, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 32'h00000103, 32'h0, 3'b000, 32'h80123456, 0, 4'b1000, 32'h0, 32'h100, 32'hFFFFFF80, 1'b1};
    vecs[2] = '{1'b0, 32'h00000103, 32'h0, 3'b100, 32'h80123456, 0, 4'b1000, 32'h0, 32'h100, 32'h00000080, 1'b1};
    vecs[3] = '{1'b1, 32'h00000102, 32'h1234ABCD, 3'b001, 32'hFFFFFFFF, 0, 4'b1100, 32'hABCDABCD, 32'h100, 32'h00000080, 1'b0};
    vecs[4] = '{1'b0, 32'h00000102, 32'h0, 3'b001, 32'h9ABC1234, 2, 4'b1100, 32'h0, 32'h100, 32'hFFFF9ABC, 1'b1};
    vecs[5] = '{1'b0, 32'h00000200, 32'h0, 3'b101, 32'h9ABCF00D, 0, 4'b0011, 32'h0, 32'h200, 32'h0000F00D, 1'b1};
    vecs[6] = '{1'b1, 32'h00000301, 32'h000000A5, 3'b000, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 32'h300, 32'h0000F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h00000001, 32'h0, 3'b000, 32'h00007F00, 3, 4'b0010, 32'h0, 32'h0, 32'h0000007F, 1'b1};
    vecs[8] = '{1'b0, 32'h00000404, 32'h0, 3'b011, 32'h01234567, 0, 4'b1111, 32'h0, 32'h404, 32'h01234567, 1'b1};
    vecs[9] = '{1'b1, 32'h0000010C, 32'hCAFEF00D, 3'b010, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h10C, 32'h01234567, 1'b0};

    rst = 1'b1; mem_en = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; ubhw = 3'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {29'd0, rdata_valid, bus_err, misalign}, 32'd0);
    chk("rst_bus", {bus_addr[27:0], bus_be}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout: no ack, request must last exactly 4 cycles.
    mem_en = 1'b1; we = 1'b0; addr = 32'h40; ubhw = 3'b010;
    @(posedge clk); #1;
    mem_en = 1'b0;
    reqc = 0;
    for (int i = 0; i < 20 && bus_req; i++) begin
      reqc++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", 32'(reqc), 32'd4);
    chk("tmo_req_drop", {31'd0, bus_req}, 32'd0);
    chk("tmo_err", {31'd0, bus_err}, 32'd1);
    chk("tmo_rdata", rdata, 32'd0);
    chk("tmo_stall", {31'd0, stall}, 32'd0);
    chk("tmo_valid", {31'd0, rdata_valid}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_err_pulse", {31'd0, bus_err}, 32'd0);

    // Stray ack in IDLE must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("stray_rdata", rdata, 32'd0);
    chk("stray_valid", {31'd0, rdata_valid}, 32'd0);
    chk("stray_req", {31'd0, bus_req}, 32'd0);

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    mem_en = 1'b1; we = 1'b0; addr = 32'h101; ubhw = 3'b010;
    #1;
    chk("mis_idle_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    mem_en = 1'b0;
    chk("mis_req", {31'd0, bus_req}, 32'd0);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_rdata", rdata, 32'd0);
    chk("mis_valid", {31'd0, rdata_valid}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse", {31'd0, misalign}, 32'd0);
`else
    mv = '{1'b0, 32'h00000101, 32'h0, 3'b010, 32'h11223344, 0, 4'b1111, 32'h0, 32'h100, 32'h11223344, 1'b1};
    run_vec(mv, "forced_align");
    chk("forced_misalign", {31'd0, misalign}, 32'd0);
`endif

    // Asynchronous reset during REQ.
    mem_en = 1'b1; we = 1'b0; addr = 32'h80; ubhw = 3'b010;
    @(posedge clk); #1;
    mem_en = 1'b0;
    chk("rreq_req_before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rreq_req", {31'd0, bus_req}, 32'd0);
    chk("rreq_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
